// File: rtl/uart_pkg.sv
// Shared types and limits for the UART receive frame timer.
package uart_pkg;

    localparam int MIN_PRESCALE = 4;
    localparam int MIN_DATA     = 5;

    typedef enum logic [1:0] {
        START  = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } field_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        ERR  = 2'd2
    } ftimer_state_e;

endpackage

// File: rtl/uart_frame_timer_if.sv
// Bundle between the RX FSM / sampler side and the frame timer.
interface uart_frame_timer_if
    import uart_pkg::*;
#(
    parameter int PRESC_W = 6,
    parameter int BIT_W   = 4
);

    logic               enable;
    logic [PRESC_W-1:0] prescale;
    logic [3:0]         data_len;
    logic               PAR_EN;
    logic               stop2;

    logic [PRESC_W-1:0] edge_count;
    logic [BIT_W-1:0]   bit_count;
    logic [2:0]         sample_stb;
    logic               bit_tick;
    logic               frame_done;
    field_e             field;
    logic               cfg_err;

    modport master (
        output enable, prescale, data_len, PAR_EN, stop2,
        input  edge_count, bit_count, sample_stb,
        input  bit_tick, frame_done, field, cfg_err
    );

    modport slave (
        input  enable, prescale, data_len, PAR_EN, stop2,
        output edge_count, bit_count, sample_stb,
        output bit_tick, frame_done, field, cfg_err
    );

endinterface

// File: rtl/uart_frame_timer.sv
// Oversampling edge/bit counter with runtime frame geometry,
// mid-bit sample strobes, bit/frame ticks and field decode.
module uart_frame_timer
    import uart_pkg::*;
#(
    parameter int PRESC_W  = 6,
    parameter int MAX_DATA = 9,
    parameter int BIT_W    = 4
) (
    input  logic              CLK,
    input  logic              RST,
    uart_frame_timer_if.slave bus
);

    localparam logic [PRESC_W-1:0] P_MIN = PRESC_W'(MIN_PRESCALE);
    localparam logic [3:0]         D_MIN = 4'(MIN_DATA);
    localparam logic [3:0]         D_MAX = 4'(MAX_DATA);
    localparam logic [PRESC_W-1:0] P_ONE = PRESC_W'(1);
    localparam logic [BIT_W-1:0]   B_ONE = BIT_W'(1);

    ftimer_state_e      state;
    logic [PRESC_W-1:0] sh_p;
    logic [3:0]         sh_len;
    logic               sh_par;
    logic               sh_s2;
    logic [PRESC_W-1:0] edge_q;
    logic [BIT_W-1:0]   bit_q;
    logic               err_q;

    logic               cfg_ok;
    logic               run;
    logic               last_edge;
    logic               last_bit;
    logic               relatch;
    logic [BIT_W-1:0]   last_idx;
    logic [BIT_W-1:0]   len_b;
    logic [PRESC_W-1:0] half;
    field_e             field_d;

    assign cfg_ok = (bus.prescale >= P_MIN)
                 && (bus.data_len >= D_MIN)
                 && (bus.data_len <= D_MAX);

    assign run       = (state == RUN);
    assign len_b     = BIT_W'(sh_len);
    assign last_idx  = len_b + BIT_W'(sh_par) + B_ONE + BIT_W'(sh_s2);
    assign last_edge = (edge_q == sh_p - P_ONE);
    assign last_bit  = (bit_q == last_idx);
    assign half      = sh_p >> 1;

    // A new frame starts from IDLE or straight off the final stop edge.
    assign relatch = (state == IDLE) || (run && last_edge && last_bit);

    always_comb begin
        field_d = STOP;
        if (bit_q == '0)
            field_d = START;
        else if (bit_q <= len_b)
            field_d = DATA;
        else if (sh_par && (bit_q == len_b + B_ONE))
            field_d = PARITY;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= IDLE;
            sh_p   <= '0;
            sh_len <= '0;
            sh_par <= 1'b0;
            sh_s2  <= 1'b0;
            edge_q <= '0;
            bit_q  <= '0;
            err_q  <= 1'b0;
        end else if (!bus.enable) begin
            state  <= IDLE;
            edge_q <= '0;
            bit_q  <= '0;
            err_q  <= 1'b0;
        end else if (relatch) begin
            sh_p   <= bus.prescale;
            sh_len <= bus.data_len;
            sh_par <= bus.PAR_EN;
            sh_s2  <= bus.stop2;
            state  <= cfg_ok ? RUN : ERR;
            err_q  <= !cfg_ok;
            edge_q <= '0;
            bit_q  <= '0;
        end else if (run) begin
            if (last_edge) begin
                edge_q <= '0;
                bit_q  <= bit_q + B_ONE;
            end else begin
                edge_q <= edge_q + P_ONE;
            end
        end else begin
            edge_q <= '0;
            bit_q  <= '0;
            err_q  <= 1'b1;
        end
    end

    assign bus.edge_count = edge_q;
    assign bus.bit_count  = bit_q;
    assign bus.cfg_err    = err_q;
    assign bus.field      = field_d;

    assign bus.bit_tick   = run && last_edge;
    assign bus.frame_done = run && last_edge && last_bit;

    assign bus.sample_stb[0] = run && (edge_q == half - P_ONE);
    assign bus.sample_stb[1] = run && (edge_q == half);
    assign bus.sample_stb[2] = run && (edge_q == half + P_ONE);

endmodule

// File: tb/tb_uart_frame_timer.sv
// Randomised and directed checks of the frame timer
// against a frame-time arithmetic reference model.
module tb_uart_frame_timer;

    logic CLK = 1'b0;
    logic RST;

    always #5 CLK = ~CLK;

    uart_frame_timer_if bus ();

    uart_frame_timer dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Model: mode 0 idle, 1 run, 2 err; m_t = cycles since frame start.
    int m_mode = 0;
    int m_t    = 0;
    int m_p    = 4;
    int m_len  = 5;
    int m_par  = 0;
    int m_s2   = 0;

    function automatic int n_bits();
        return 2 + m_len + m_par + m_s2;
    endfunction

    function automatic logic [17:0] exp_vec();
        int e;
        int b;
        int m;
        logic [2:0] s;
        logic tk;
        logic dn;
        logic [1:0] f;
        if (m_mode == 2) return 18'd1;
        if (m_mode != 1) return 18'd0;
        e = m_t % m_p;
        b = m_t / m_p;
        m = m_p / 2;
        s = {e == m + 1, e == m, e == m - 1};
        tk = (e == m_p - 1);
        dn = tk && (b == n_bits() - 1);
        if (b == 0) f = 2'd0;
        else if (b <= m_len) f = 2'd1;
        else if (m_par == 1 && b == m_len + 1) f = 2'd2;
        else f = 2'd3;
        return {6'(e), 4'(b), s, tk, dn, f, 1'b0};
    endfunction

    function automatic logic [17:0] obs_vec();
        return {bus.edge_count, bus.bit_count, bus.sample_stb,
                bus.bit_tick, bus.frame_done, 2'(bus.field), bus.cfg_err};
    endfunction

    task automatic cycle(input logic en, input int p, input int len,
                         input int par, input int s2, input logic rst = 1'b0);
        RST           = rst;
        bus.enable    = en;
        bus.prescale  = 6'(p);
        bus.data_len  = 4'(len);
        bus.PAR_EN    = par[0];
        bus.stop2     = s2[0];
        if (rst || !en) begin
            m_mode = 0;
            m_t    = 0;
        end else if (m_mode == 0 || (m_mode == 1 && m_t == n_bits() * m_p - 1)) begin
            m_p   = p;
            m_len = len;
            m_par = par;
            m_s2  = s2;
            m_t   = 0;
            m_mode = (p >= 4 && len >= 5 && len <= 9) ? 1 : 2;
        end else if (m_mode == 1) begin
            m_t++;
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 8, 8, 0, 0, 1'b1);
            checks++;
            if (obs_vec() !== 18'd0) begin
                failures++;
                $display("FAIL reset got=%h exp=0", obs_vec());
            end
        end
        cycle(1'b0, 8, 8, 0, 0);
    endtask

    task automatic test_basic();
        int done_cyc = 0;
        int ticks = 0;
        int stb_e [3] = '{-1, -1, -1};
        cycle(1'b1, 8, 8, 0, 0);
        for (int c = 1; c <= 90; c++) begin
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL basic c=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
            end
            if (bus.frame_done && done_cyc == 0) done_cyc = c;
            if (bus.bit_tick && c <= 80) ticks++;
            for (int k = 0; k < 3; k++)
                if (bus.sample_stb[k] && c <= 8) stb_e[k] = int'(bus.edge_count);
            cycle(1'b1, 8, 8, 0, 0);
        end
        checks++;
        if (done_cyc !== 80) begin
            failures++;
            $display("FAIL basic_done got=%0d exp=80", done_cyc);
        end
        checks++;
        if (ticks !== 10) begin
            failures++;
            $display("FAIL basic_ticks got=%0d exp=10", ticks);
        end
        checks++;
        if (stb_e[0] !== 3 || stb_e[1] !== 4 || stb_e[2] !== 5) begin
            failures++;
            $display("FAIL basic_stb got=%0d,%0d,%0d exp=3,4,5",
                     stb_e[0], stb_e[1], stb_e[2]);
        end
        cycle(1'b0, 8, 8, 0, 0);
    endtask

    task automatic test_parity_stop2();
        int done_cyc = 0;
        cycle(1'b1, 16, 7, 1, 1);
        for (int c = 1; c <= 180; c++) begin
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL par c=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
            end
            if (bus.edge_count == 6'd0 && c <= 176) begin
                if (bus.bit_count == 4'd8) begin
                    checks++;
                    if (2'(bus.field) !== 2'd2) begin
                        failures++;
                        $display("FAIL par_field got=%0d exp=2", bus.field);
                    end
                end
                if (bus.bit_count >= 4'd9) begin
                    checks++;
                    if (2'(bus.field) !== 2'd3) begin
                        failures++;
                        $display("FAIL stop_field got=%0d exp=3", bus.field);
                    end
                end
            end
            if (bus.frame_done && done_cyc == 0) done_cyc = c;
            cycle(1'b1, 16, 7, 1, 1);
        end
        checks++;
        if (done_cyc !== 176) begin
            failures++;
            $display("FAIL par_done got=%0d exp=176", done_cyc);
        end
        cycle(1'b0, 8, 8, 0, 0);
    endtask

    task automatic test_back_to_back();
        int d1 = 0;
        int d2 = 0;
        cycle(1'b1, 8, 8, 0, 0);
        for (int c = 1; c <= 125; c++) begin
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL b2b c=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
            end
            if (bus.frame_done) begin
                if (d1 == 0) d1 = c;
                else if (d2 == 0) d2 = c;
            end
            cycle(1'b1, (c < 40) ? 8 : 4, 8, 0, 0);
        end
        checks++;
        if (d1 !== 80 || d2 !== 120) begin
            failures++;
            $display("FAIL b2b_done got=%0d,%0d exp=80,120", d1, d2);
        end
        cycle(1'b0, 8, 8, 0, 0);
    endtask

    task automatic test_abort();
        bit hit = 0;
        cycle(1'b1, 8, 8, 0, 0);
        for (int c = 0; c < 200 && !hit; c++) begin
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL abort_run c=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
            end
            if (bus.bit_count == 4'd3 && bus.edge_count == 6'd5) hit = 1;
            else cycle(1'b1, 8, 8, 0, 0);
        end
        checks++;
        if (!hit) begin
            failures++;
            $display("FAIL abort_reach got=0 exp=1");
        end
        cycle(1'b0, 8, 8, 0, 0);
        checks++;
        if (obs_vec() !== 18'd0) begin
            failures++;
            $display("FAIL abort got=%h exp=0", obs_vec());
        end
    endtask

    task automatic test_cfg_err();
        int bad_p [3] = '{3, 8, 8};
        int bad_l [3] = '{8, 10, 4};
        for (int k = 0; k < 3; k++) begin
            for (int c = 0; c < 5; c++) begin
                cycle(1'b1, bad_p[k], bad_l[k], 0, 0);
                checks++;
                if (obs_vec() !== 18'd1) begin
                    failures++;
                    $display("FAIL cfg_err k=%0d got=%h exp=1", k, obs_vec());
                end
            end
            cycle(1'b0, bad_p[k], bad_l[k], 0, 0);
            checks++;
            if (obs_vec() !== 18'd0) begin
                failures++;
                $display("FAIL cfg_clr k=%0d got=%h exp=0", k, obs_vec());
            end
        end
    endtask

    task automatic test_reset_mid();
        cycle(1'b1, 8, 8, 0, 0);
        for (int c = 0; c < 30; c++) cycle(1'b1, 8, 8, 0, 0);
        cycle(1'b1, 8, 8, 0, 0, 1'b1);
        checks++;
        if (obs_vec() !== 18'd0) begin
            failures++;
            $display("FAIL rst_mid got=%h exp=0", obs_vec());
        end
        cycle(1'b1, 8, 8, 0, 0);
        cycle(1'b1, 8, 8, 0, 0);
        checks++;
        if (bus.edge_count !== 6'd1 || bus.bit_count !== 4'd0) begin
            failures++;
            $display("FAIL rst_restart got=%0d/%0d exp=1/0",
                     bus.edge_count, bus.bit_count);
        end
        cycle(1'b0, 8, 8, 0, 0);
    endtask

    task automatic test_random();
        int errs = 0;
        for (int c = 0; c < 3000; c++) begin
            cycle($urandom_range(0, 149) != 0,
                  $urandom_range(3, 12), $urandom_range(4, 10),
                  $urandom_range(0, 1), $urandom_range(0, 1));
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                errs++;
                if (errs < 10)
                    $display("FAIL random c=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
            end
        end
        cycle(1'b0, 8, 8, 0, 0);
    endtask

    initial begin
        RST          = 1'b1;
        bus.enable   = 1'b0;
        bus.prescale = '0;
        bus.data_len = '0;
        bus.PAR_EN   = 1'b0;
        bus.stop2    = 1'b0;
        @(posedge CLK);
        #1;
        test_reset();
        test_basic();
        test_parity_stop2();
        test_back_to_back();
        test_abort();
        test_cfg_err();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
